// File: rtl/sponge_trigger_if.sv
// Request/status bundle between the tour logic, the pacing stage and the tune player.
// The master side drives requests and control; the slave side (sponge_trigger) returns go and status.
interface sponge_trigger_if;
   logic       en;
   logic       move_chime;
   logic       move_done;
   logic       tour_done;
   logic       flush;
   logic       go;
   logic       busy;
   logic [1:0] pend_cnt;

   modport master (
      output en, move_chime, move_done, tour_done, flush,
      input  go, busy, pend_cnt
   );

   modport slave (
      input  en, move_chime, move_done, tour_done, flush,
      output go, busy, pend_cnt
   );
endinterface

// File: rtl/sponge_trigger.sv
// Queues up to MAX_PEND play requests and paces single-cycle go pulses to the tune player,
// holding off at least one full tune between pulses so no tune is restarted mid-play.
module sponge_trigger #(
   parameter bit FAST_SIM    = 1'b1,
   parameter int HOLD_CYCLES = 67109120,
   parameter int MAX_PEND    = 3
) (
   input logic             clk,
   input logic             rst,
   sponge_trigger_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [26:0] INC      = FAST_SIM ? 27'd16 : 27'd1;
   localparam logic [26:0] HOLD_LIM = 27'(HOLD_CYCLES);
   localparam logic [2:0]  PEND_MAX = 3'(MAX_PEND);

   state_t      state;
   state_t      state_next;
   logic [1:0]  pend;
   logic [1:0]  pend_next;
   logic [26:0] hold_cnt;
   logic [26:0] hold_next;
   logic        go_q;
   logic [1:0]  req_n;
   logic [1:0]  req_eff;
   logic        take;
   logic [2:0]  sum;
   logic [2:0]  diff;

   // A move and a tour completing together count as two requests.
   always_comb begin
      req_n = 2'd0;
      if (bus.en) begin
         req_n = {1'b0, bus.move_done & bus.move_chime} + {1'b0, bus.tour_done};
      end
      req_eff = bus.flush ? 2'd0 : req_n;
   end

   // Pending count: the request that launches a FIRE is consumed as the FSM leaves FIRE.
   // The floor at zero only matters if a flush emptied the queue just before a FIRE.
   always_comb begin
      take      = (state == FIRE);
      sum       = {1'b0, pend} + {1'b0, req_n};
      diff      = (sum < 3'(take)) ? 3'd0 : sum - 3'(take);
      pend_next = (diff > PEND_MAX) ? PEND_MAX[1:0] : diff[1:0];
      if (bus.flush) begin
         pend_next = 2'd0;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      case (state)
         IDLE: begin
            hold_next = 27'd0;
            if ((pend != 2'd0) || (req_eff != 2'd0)) begin
               state_next = FIRE;
            end
         end
         FIRE: begin
            hold_next  = 27'd0;
            state_next = HOLD;
         end
         HOLD: begin
            hold_next = hold_cnt + INC;
            if (hold_cnt >= HOLD_LIM) begin
               state_next = (pend != 2'd0) ? FIRE : IDLE;
            end
         end
         default: begin
            hold_next  = 27'd0;
            state_next = IDLE;
         end
      endcase
   end

   // go is registered from the next state so it lines up exactly with the FIRE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pend     <= 2'd0;
         hold_cnt <= 27'd0;
         go_q     <= 1'b0;
      end else begin
         state    <= state_next;
         pend     <= pend_next;
         hold_cnt <= hold_next;
         go_q     <= (state_next == FIRE);
      end
   end

   assign bus.go       = go_q;
   assign bus.busy     = (state != IDLE);
   assign bus.pend_cnt = pend;

endmodule
